// File: rtl/hpdcache_cmo_arb.sv
// Round-robin arbiter that funnels cache-maintenance requests from NREQ
// requesters to a single CMO handler, one outstanding request at a time.
module hpdcache_cmo_arb #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 49,
  parameter int WDATA_W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [4*NREQ-1:0]         req_op_i,
  input  logic [ADDR_W*NREQ-1:0]    req_addr_i,
  input  logic [WDATA_W*NREQ-1:0]   req_wdata_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  output logic                      rsp_error_o,
  output logic                      cmo_req_valid_o,
  input  logic                      cmo_req_ready_i,
  output logic [3:0]                cmo_req_op_o,
  output logic [ADDR_W-1:0]         cmo_req_addr_o,
  output logic [WDATA_W-1:0]        cmo_req_wdata_o,
  output logic                      busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     id_q;
  logic                 err_q;
  logic                 cmo_valid_q;
  logic [NREQ-1:0]      rsp_valid_q;
  logic                 rsp_error_q;
  logic                 busy_q;
  logic [3:0]           op_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WDATA_W-1:0]   wdata_q;

  logic                 grant_any_s;
  logic [PTR_W-1:0]     winner_s;
  logic [NREQ-1:0]      grant_oh_s;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [3:0]           sel_op_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [WDATA_W-1:0]   sel_wdata_s;

  function automatic logic is_onehot(input logic [3:0] op);
    return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
  endfunction

  // Two passes: first requesters at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    grant_any_s = 1'b0;
    winner_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any_s && req_valid_i[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        grant_any_s = 1'b1;
        winner_s    = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any_s && req_valid_i[i]) begin
        grant_any_s = 1'b1;
        winner_s    = PTR_W'(i);
      end
    end
  end

  always_comb begin
    sel_op_s    = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == winner_s) begin
        sel_op_s    = req_op_i[i*4 +: 4];
        sel_addr_s  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata_s = req_wdata_i[i*WDATA_W +: WDATA_W];
      end
    end
  end

  assign grant_oh_s  = NREQ'(1) << winner_s;
  assign rr_ptr_d    = (winner_s == PTR_W'(NREQ - 1)) ? '0 : winner_s + PTR_W'(1);
  assign req_ready_o = (state_q == IDLE && grant_any_s) ? grant_oh_s : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      cmo_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any_s) begin
            id_q     <= winner_s;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            if (is_onehot(sel_op_s)) begin
              err_q       <= 1'b0;
              cmo_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              // Illegal op: skip the handler and answer with an error next cycle.
              err_q       <= 1'b1;
              rsp_valid_q <= grant_oh_s;
              rsp_error_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cmo_req_ready_i) begin
            cmo_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cmo_req_ready_i) begin
            rsp_valid_q <= NREQ'(1) << id_q;
            rsp_error_q <= err_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_error_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          cmo_valid_q <= 1'b0;
          rsp_valid_q <= '0;
          rsp_error_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Payload capture; contents only matter while cmo_req_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && grant_any_s) begin
      op_q    <= sel_op_s;
      addr_q  <= sel_addr_s;
      wdata_q <= sel_wdata_s;
    end
  end

  assign cmo_req_valid_o = cmo_valid_q;
  assign cmo_req_op_o    = op_q;
  assign cmo_req_addr_o  = addr_q;
  assign cmo_req_wdata_o = wdata_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_error_o     = rsp_error_q;
  assign busy_o          = busy_q;

endmodule
